// File: rtl/i2c_master_defines.sv
// Bit-level command encodings shared by the byte sequencer and the bit controller.
package i2c_master_defines;

    typedef enum logic [3:0] {
        BIT_NOP   = 4'b0000,
        BIT_START = 4'b0001,
        BIT_STOP  = 4'b0010,
        BIT_WRITE = 4'b0100,
        BIT_READ  = 4'b1000
    } bit_cmd_e;

endpackage

// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C sequencer: turns Start/Stop/Read/Write requests from the register
// block into single-bit commands for the bit controller and reports the result back.
module i2c_master_byte_ctrl
    import i2c_master_defines::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  I2C_en,
    input  logic                  Start,
    input  logic                  Stop,
    input  logic                  Read,
    input  logic                  Write,
    input  logic                  Tx_ack,
    input  logic [DATA_WIDTH-1:0] Tx_data,
    output logic [DATA_WIDTH-1:0] Rx_data,
    output logic                  Rx_ack,
    output logic                  I2C_done,
    output logic                  I2C_al,
    output logic [3:0]            Bit_cmd,
    output logic                  Bit_txd,
    input  logic                  Bit_ack,
    input  logic                  Bit_rxd,
    input  logic                  Bit_al
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_WRITE = 3'd2,
        ST_READ  = 3'd3,
        ST_ACK   = 3'd4,
        ST_STOP  = 3'd5
    } state_e;

    state_e                state, state_n;
    logic [DATA_WIDTH-1:0] sr, sr_n;
    logic [CNT_W-1:0]      cnt, cnt_n;
    logic [3:0]            cmd_n;
    logic                  txd_n;
    logic                  rx_ack_n;
    logic                  done_n;
    logic                  al_n;
    logic                  wr_xfer, wr_xfer_n;
    logic                  launch;

    assign Rx_data = sr;

    always_comb begin
        state_n   = state;
        sr_n      = sr;
        cnt_n     = cnt;
        cmd_n     = Bit_cmd;
        txd_n     = Bit_txd;
        rx_ack_n  = Rx_ack;
        wr_xfer_n = wr_xfer;
        done_n    = 1'b0;
        al_n      = 1'b0;
        launch    = I2C_en && !I2C_done && (Start || Stop || Read || Write);

        // Arbitration loss outranks everything, including a coincident Bit_ack.
        if (Bit_al) begin
            state_n = ST_IDLE;
            cmd_n   = BIT_NOP;
            al_n    = 1'b1;
        end else if (!I2C_en && state != ST_IDLE) begin
            state_n = ST_IDLE;
            cmd_n   = BIT_NOP;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (launch) begin
                        sr_n  = Tx_data;
                        cnt_n = CNT_LAST;
                        if (Start) begin
                            state_n = ST_START;
                            cmd_n   = BIT_START;
                        end else if (Read) begin
                            state_n = ST_READ;
                            cmd_n   = BIT_READ;
                        end else if (Write) begin
                            state_n = ST_WRITE;
                            cmd_n   = BIT_WRITE;
                            txd_n   = Tx_data[DATA_WIDTH-1];
                        end else begin
                            state_n = ST_STOP;
                            cmd_n   = BIT_STOP;
                        end
                    end
                end
                ST_START: begin
                    if (Bit_ack) begin
                        if (Read) begin
                            state_n = ST_READ;
                            cmd_n   = BIT_READ;
                        end else if (Write) begin
                            state_n = ST_WRITE;
                            cmd_n   = BIT_WRITE;
                            txd_n   = sr[DATA_WIDTH-1];
                        end else if (Stop) begin
                            state_n = ST_STOP;
                            cmd_n   = BIT_STOP;
                        end else begin
                            state_n = ST_IDLE;
                            cmd_n   = BIT_NOP;
                            done_n  = 1'b1;
                        end
                    end
                end
                ST_WRITE: begin
                    if (Bit_ack) begin
                        sr_n = {sr[DATA_WIDTH-2:0], 1'b0};
                        if (cnt == '0) begin
                            state_n   = ST_ACK;
                            cmd_n     = BIT_READ;
                            wr_xfer_n = 1'b1;
                        end else begin
                            cnt_n = cnt - CNT_ONE;
                            cmd_n = BIT_WRITE;
                            txd_n = sr[DATA_WIDTH-2];
                        end
                    end
                end
                ST_READ: begin
                    if (Bit_ack) begin
                        sr_n = {sr[DATA_WIDTH-2:0], Bit_rxd};
                        if (cnt == '0) begin
                            state_n   = ST_ACK;
                            cmd_n     = BIT_WRITE;
                            txd_n     = Tx_ack;
                            wr_xfer_n = 1'b0;
                        end else begin
                            cnt_n = cnt - CNT_ONE;
                        end
                    end
                end
                ST_ACK: begin
                    if (Bit_ack) begin
                        if (wr_xfer) begin
                            rx_ack_n = Bit_rxd;
                        end
                        if (Stop) begin
                            state_n = ST_STOP;
                            cmd_n   = BIT_STOP;
                        end else begin
                            state_n = ST_IDLE;
                            cmd_n   = BIT_NOP;
                            done_n  = 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (Bit_ack) begin
                        state_n = ST_IDLE;
                        cmd_n   = BIT_NOP;
                        done_n  = 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cmd_n   = BIT_NOP;
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= ST_IDLE;
            sr       <= '0;
            cnt      <= '0;
            wr_xfer  <= 1'b0;
            Bit_cmd  <= BIT_NOP;
            Bit_txd  <= 1'b0;
            Rx_ack   <= 1'b0;
            I2C_done <= 1'b0;
            I2C_al   <= 1'b0;
        end else begin
            state    <= state_n;
            sr       <= sr_n;
            cnt      <= cnt_n;
            wr_xfer  <= wr_xfer_n;
            Bit_cmd  <= cmd_n;
            Bit_txd  <= txd_n;
            Rx_ack   <= rx_ack_n;
            I2C_done <= done_n;
            I2C_al   <= al_n;
        end
    end

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Randomised scoreboard bench for the byte sequencer with a behavioural bit-controller/slave.
`timescale 1ns/1ps
module tb_i2c_master_byte_ctrl;
    import i2c_master_defines::*;

    logic       Clk = 1'b0;
    logic       Rst, I2C_en, Start, Stop, Read, Write, Tx_ack;
    logic [7:0] Tx_data, Rx_data;
    logic       Rx_ack, I2C_done, I2C_al;
    logic [3:0] Bit_cmd;
    logic       Bit_txd, Bit_ack, Bit_rxd, Bit_al;

    i2c_master_byte_ctrl #(.DATA_WIDTH(8)) dut (
        .Clk(Clk), .Rst(Rst), .I2C_en(I2C_en),
        .Start(Start), .Stop(Stop), .Read(Read), .Write(Write),
        .Tx_ack(Tx_ack), .Tx_data(Tx_data), .Rx_data(Rx_data),
        .Rx_ack(Rx_ack), .I2C_done(I2C_done), .I2C_al(I2C_al),
        .Bit_cmd(Bit_cmd), .Bit_txd(Bit_txd), .Bit_ack(Bit_ack),
        .Bit_rxd(Bit_rxd), .Bit_al(Bit_al)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit         is_al;
        logic [7:0] rx_data;
        logic       rx_ack;
        bit         chk_data;
        int         n_cmds;
    } exp_t;

    exp_t       sb_q[$];
    logic [4:0] exp_cmd_q[$];
    logic [4:0] log_q[$];
    logic       rxd_q[$];
    int         checks = 0;
    int         errors = 0;
    int         al_mode = 0;
    int         wr_acks = 0;
    int         rd_acks = 0;
    int         bc_max_dly = 3;
    logic       ref_rx_ack = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bit controller + slave: acks each non-NOP command after a random delay.
    initial begin
        int dly;
        dly = 0;
        Bit_ack = 1'b0;
        Bit_al = 1'b0;
        Bit_rxd = 1'b0;
        forever begin
            @(negedge Clk);
            Bit_rxd = 1'($urandom);
            if (Bit_ack || Bit_al) begin
                Bit_ack = 1'b0;
                Bit_al = 1'b0;
                dly = int'($urandom_range(bc_max_dly, 0));
            end else if (Bit_cmd == BIT_NOP || Rst) begin
                dly = int'($urandom_range(bc_max_dly, 0));
            end else if (dly > 0) begin
                dly--;
            end else if (al_mode != 0 && Bit_cmd == BIT_WRITE && wr_acks == 3) begin
                Bit_al = 1'b1;
                Bit_ack = (al_mode == 2);
                al_mode = 0;
            end else begin
                Bit_ack = 1'b1;
                if (Bit_cmd == BIT_READ) begin
                    Bit_rxd = (rxd_q.size() > 0) ? rxd_q.pop_front() : 1'b1;
                    rd_acks++;
                end
                if (Bit_cmd == BIT_WRITE) wr_acks++;
                log_q.push_back({Bit_cmd, (Bit_cmd == BIT_WRITE) ? Bit_txd : 1'b0});
            end
        end
    end

    // Monitor: pops one expectation per done/al pulse.
    initial begin
        exp_t e;
        logic prev_done, prev_al;
        logic [4:0] ec;
        prev_done = 1'b0;
        prev_al = 1'b0;
        forever begin
            @(negedge Clk);
            if (I2C_done || I2C_al) begin
                check("done_al_exclusive", {31'd0, I2C_done & I2C_al}, 0);
                check("pulse_width", {30'd0, prev_done & I2C_done, prev_al & I2C_al}, 0);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got done=%0b al=%0b expected none", I2C_done, I2C_al);
                end else begin
                    e = sb_q.pop_front();
                    check("event_is_al", {31'd0, I2C_al}, {31'd0, e.is_al});
                    check("cmd_nop_at_event", Bit_cmd, BIT_NOP);
                    check("rx_ack", {31'd0, Rx_ack}, {31'd0, e.rx_ack});
                    if (e.chk_data) check("rx_data", Rx_data, e.rx_data);
                    if (!e.is_al) begin
                        check("bit_cmd_count", log_q.size(), e.n_cmds);
                        for (int i = 0; i < e.n_cmds; i++) begin
                            ec = exp_cmd_q.pop_front();
                            if (i < log_q.size()) check($sformatf("bit_cmd_seq[%0d]", i), log_q[i], ec);
                        end
                    end
                end
                log_q.delete();
            end
            prev_done = I2C_done;
            prev_al = I2C_al;
        end
    end

    // Reference: the bit commands a byte transfer must produce, from the request flags.
    task automatic ref_model(input bit st, input bit sp, input bit rd, input bit wr,
                             input logic [7:0] txd, input logic txack,
                             input logic [7:0] rxb, input logic sack, output exp_t e);
        e.is_al = 0;
        e.chk_data = 1;
        e.n_cmds = 0;
        if (st) begin exp_cmd_q.push_back({BIT_START, 1'b0}); e.n_cmds++; end
        if (rd) begin
            for (int i = 0; i < 8; i++) begin exp_cmd_q.push_back({BIT_READ, 1'b0}); e.n_cmds++; end
            exp_cmd_q.push_back({BIT_WRITE, txack});
            e.n_cmds++;
            e.rx_data = rxb;
        end else if (wr) begin
            for (int i = 7; i >= 0; i--) begin exp_cmd_q.push_back({BIT_WRITE, txd[i]}); e.n_cmds++; end
            exp_cmd_q.push_back({BIT_READ, 1'b0});
            e.n_cmds++;
            e.rx_data = 8'h00;
            ref_rx_ack = sack;
        end else begin
            e.rx_data = txd;
        end
        if (sp) begin exp_cmd_q.push_back({BIT_STOP, 1'b0}); e.n_cmds++; end
        e.rx_ack = ref_rx_ack;
    endtask

    task automatic clear_cmds();
        Start = 1'b0; Stop = 1'b0; Read = 1'b0; Write = 1'b0;
    endtask

    task automatic prep(input bit rd, input bit wr, input logic [7:0] rxb, input logic sack);
        log_q.delete();
        rxd_q.delete();
        wr_acks = 0;
        rd_acks = 0;
        if (rd) for (int i = 7; i >= 0; i--) rxd_q.push_back(rxb[i]);
        else if (wr) rxd_q.push_back(sack);
    endtask

    task automatic run_xfer(input bit st, input bit sp, input bit rd, input bit wr,
                            input logic [7:0] txd, input logic txack,
                            input logic [7:0] rxb, input logic sack, input int amode);
        exp_t e;
        int n;
        @(negedge Clk);
        prep(rd, wr, rxb, sack);
        if (amode != 0) begin
            e.is_al = 1; e.rx_data = 8'h00; e.rx_ack = ref_rx_ack; e.chk_data = 0; e.n_cmds = 0;
            al_mode = amode;
        end else begin
            ref_model(st, sp, rd, wr, txd, txack, rxb, sack, e);
        end
        sb_q.push_back(e);
        Start = st; Stop = sp; Read = rd; Write = wr; Tx_data = txd; Tx_ack = txack;
        n = 0;
        while (!(I2C_done || I2C_al) && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 1000) begin
            checks++;
            errors++;
            $display("FAIL xfer_timeout: got no done/al after %0d cycles expected one", n);
            sb_q.delete();
            exp_cmd_q.delete();
            clear_cmds();
        end else if (I2C_al) begin
            clear_cmds();
        end else begin
            // Command bits stay set across the done cycle, as the register block would leave them.
            @(negedge Clk);
            check("no_relaunch_while_done", Bit_cmd, BIT_NOP);
            clear_cmds();
        end
        al_mode = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got simulation still running expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, bad;
        bit st, sp, rd, wr;
        Rst = 1'b1; I2C_en = 1'b0; Tx_ack = 1'b0; Tx_data = 8'h00;
        clear_cmds();
        repeat (3) @(negedge Clk);
        check("rst_bit_cmd", Bit_cmd, BIT_NOP);
        check("rst_bit_txd", {31'd0, Bit_txd}, 0);
        check("rst_rx_data", Rx_data, 8'h00);
        check("rst_rx_ack", {31'd0, Rx_ack}, 0);
        check("rst_done_al", {30'd0, I2C_done, I2C_al}, 0);
        Rst = 1'b0;
        I2C_en = 1'b1;

        run_xfer(1, 0, 0, 1, 8'hA5, 1'b0, 8'h00, 1'b0, 0);
        run_xfer(0, 1, 1, 0, 8'h00, 1'b1, 8'h3C, 1'b0, 0);
        run_xfer(0, 0, 0, 1, 8'h5A, 1'b0, 8'h00, 1'b1, 0);
        run_xfer(1, 1, 0, 0, 8'h77, 1'b0, 8'h00, 1'b0, 0);
        run_xfer(0, 0, 0, 1, 8'hF0, 1'b0, 8'h00, 1'b0, 1);
        run_xfer(1, 0, 0, 1, 8'h0F, 1'b0, 8'h00, 1'b0, 2);
        run_xfer(0, 1, 0, 1, 8'hC3, 1'b0, 8'h00, 1'b0, 0);

        // Reset while the fifth read bit is outstanding.
        @(negedge Clk);
        prep(1, 0, 8'h96, 1'b0);
        Read = 1'b1; Stop = 1'b1; Tx_ack = 1'b0;
        n = 0;
        while (!(rd_acks == 4 && !Bit_ack && Bit_cmd == BIT_READ) && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        check("reach_read_bit5", {31'd0, n >= 1000}, 0);
        Rst = 1'b1;
        clear_cmds();
        @(negedge Clk);
        Rst = 1'b0;
        ref_rx_ack = 1'b0;
        check("midrst_bit_cmd", Bit_cmd, BIT_NOP);
        check("midrst_rx_data", Rx_data, 8'h00);
        check("midrst_rx_ack", {31'd0, Rx_ack}, 0);
        check("midrst_txd_done_al", {29'd0, Bit_txd, I2C_done, I2C_al}, 0);
        run_xfer(0, 0, 0, 1, 8'h81, 1'b0, 8'h00, 1'b0, 0);

        // Disabled core must not launch; dropping enable mid-write aborts quietly.
        @(negedge Clk);
        prep(0, 1, 8'h00, 1'b0);
        I2C_en = 1'b0; Write = 1'b1; Tx_data = 8'h6E;
        bad = 0;
        repeat (20) begin
            @(negedge Clk);
            if (Bit_cmd != BIT_NOP) bad++;
        end
        check("en_low_no_launch", bad, 0);
        I2C_en = 1'b1;
        n = 0;
        while (wr_acks < 2 && n < 1000) begin
            @(negedge Clk);
            n++;
        end
        check("reach_write_bit3", {31'd0, n >= 1000}, 0);
        I2C_en = 1'b0;
        @(negedge Clk);
        check("en_abort_cmd", Bit_cmd, BIT_NOP);
        check("en_abort_done_al", {30'd0, I2C_done, I2C_al}, 0);
        check("en_abort_rx_ack", {31'd0, Rx_ack}, {31'd0, ref_rx_ack});
        clear_cmds();
        repeat (3) @(negedge Clk);
        I2C_en = 1'b1;

        for (int k = 0; k < 40; k++) begin
            st = 1'($urandom); sp = 1'($urandom); rd = 1'($urandom); wr = 1'($urandom);
            if (!(st || sp || rd || wr)) wr = 1'b1;
            bc_max_dly = int'($urandom_range(4, 0));
            run_xfer(st, sp, rd, wr, 8'($urandom), 1'($urandom), 8'($urandom), 1'($urandom), 0);
        end

        repeat (5) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
